// File: rtl/iiitb_ptv_pkg.sv
// Shared definitions for the ticket-machine coin interface and the change dispenser FSM.
package iiitb_ptv_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } disp_state_e;

  // Value of a coin code in 5-rupee units.
  function automatic logic [1:0] coin_units(input logic [1:0] code);
    logic [1:0] units;
    case (code)
      COIN_10: units = 2'd2;
      COIN_5:  units = 2'd1;
      default: units = 2'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/iiitb_ptv_ack_timer.sv
// Hopper acknowledge watchdog: clearable counter that flags expiry in its ACK_TIMEOUT-th counted cycle.
module iiitb_ptv_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_r;

  assign expired = (cnt_r == CNT_W'(ACK_TIMEOUT - 1));

  // Count waiting cycles, holding at the expiry value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && !expired) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/iiitb_ptv_change_dispenser.sv
// Greedy change dispenser (tens then fives) driving a one-coin-per-handshake hopper.
// Stock tracking is compiled in with PTV_CHANGE_STOCK_EN; otherwise stock is unlimited.
module iiitb_ptv_change_dispenser
  import iiitb_ptv_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int STOCK_W     = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [AMT_W-1:0]   req_amount,
  output logic               req_ready,
  output logic [1:0]         coin,
  output logic               coin_valid,
  input  logic               coin_ack,
  input  logic               load,
  input  logic [STOCK_W-1:0] load_tens,
  input  logic [STOCK_W-1:0] load_fives,
  input  logic               clr_fault,
  output logic               done,
  output logic               short,
  output logic [AMT_W-1:0]   remaining,
  output logic               fault,
  output logic [STOCK_W-1:0] stock_tens,
  output logic [STOCK_W-1:0] stock_fives
);

  disp_state_e      state_r, state_nxt_s;
  logic [AMT_W-1:0] rem_r;
  logic [1:0]       sel_coin_s;
  logic             timer_clr_s, timer_en_s, timer_exp_s;

  logic             req_ready_r, coin_valid_r, done_r, short_r, fault_r;
  logic [1:0]       coin_r;
  logic [AMT_W-1:0] remaining_r;
  logic             req_ready_nxt_s, coin_valid_nxt_s, done_nxt_s, short_nxt_s, fault_nxt_s;
  logic [1:0]       coin_nxt_s;
  logic [AMT_W-1:0] remaining_nxt_s;

`ifdef PTV_CHANGE_STOCK_EN
  logic [STOCK_W-1:0] stock_tens_r, stock_fives_r;

  // Coin stock: bulk load while idle, one decrement per acknowledged coin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stock_tens_r  <= '0;
      stock_fives_r <= '0;
    end else if (state_r == ST_IDLE && load) begin
      stock_tens_r  <= load_tens;
      stock_fives_r <= load_fives;
    end else if (state_r == ST_ISSUE && coin_ack) begin
      if (coin_r == COIN_10 && stock_tens_r != '0) stock_tens_r <= stock_tens_r - STOCK_W'(1'b1);
      if (coin_r == COIN_5 && stock_fives_r != '0) stock_fives_r <= stock_fives_r - STOCK_W'(1'b1);
    end
  end

  assign stock_tens  = stock_tens_r;
  assign stock_fives = stock_fives_r;

  // Greedy pick limited by stock; never overpay a lone five-unit remainder with a ten.
  always_comb begin
    sel_coin_s = COIN_NONE;
    if (rem_r == '0) begin
      sel_coin_s = COIN_NONE;
    end else if (rem_r >= AMT_W'(2'd2) && stock_tens_r != '0) begin
      sel_coin_s = COIN_10;
    end else if (stock_fives_r != '0) begin
      sel_coin_s = COIN_5;
    end else begin
      sel_coin_s = COIN_NONE;
    end
  end
`else
  logic unused_load_s;
  assign unused_load_s = ^{load, load_tens, load_fives};
  assign stock_tens    = '0;
  assign stock_fives   = '0;

  // Greedy pick with unlimited stock.
  always_comb begin
    sel_coin_s = COIN_NONE;
    if (rem_r >= AMT_W'(2'd2)) begin
      sel_coin_s = COIN_10;
    end else if (rem_r != '0) begin
      sel_coin_s = COIN_5;
    end else begin
      sel_coin_s = COIN_NONE;
    end
  end
`endif

  assign timer_clr_s = (state_r == ST_SEL);
  assign timer_en_s  = (state_r == ST_ISSUE) && !coin_ack;

  iiitb_ptv_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr_s),
    .en     (timer_en_s),
    .expired(timer_exp_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (req_valid) state_nxt_s = ST_SEL; else state_nxt_s = ST_IDLE;
      ST_SEL:   if (sel_coin_s != COIN_NONE) state_nxt_s = ST_ISSUE; else state_nxt_s = ST_DONE;
      ST_ISSUE: begin
        if (coin_ack)         state_nxt_s = ST_SEL;
        else if (timer_exp_s) state_nxt_s = ST_FAULT;
        else                  state_nxt_s = ST_ISSUE;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      ST_FAULT: if (clr_fault) state_nxt_s = ST_IDLE; else state_nxt_s = ST_FAULT;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Remaining-change register; a faulted request is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE:  if (req_valid) rem_r <= req_amount;
        ST_ISSUE: begin
          if (coin_ack)         rem_r <= rem_r - AMT_W'(coin_units(coin_r));
          else if (timer_exp_s) rem_r <= '0;
        end
        ST_FAULT: rem_r <= '0;
        default:  rem_r <= rem_r;
      endcase
    end
  end

  // Output decode from the upcoming state so every output comes straight from a flop.
  always_comb begin
    req_ready_nxt_s  = (state_nxt_s == ST_IDLE);
    coin_valid_nxt_s = (state_nxt_s == ST_ISSUE);
    done_nxt_s       = (state_nxt_s == ST_DONE);
    fault_nxt_s      = (state_nxt_s == ST_FAULT);
    coin_nxt_s       = COIN_NONE;
    short_nxt_s      = 1'b0;
    remaining_nxt_s  = '0;
    if (state_nxt_s == ST_ISSUE) begin
      coin_nxt_s = (state_r == ST_SEL) ? sel_coin_s : coin_r;
    end else begin
      coin_nxt_s = COIN_NONE;
    end
    if (state_nxt_s == ST_DONE) begin
      short_nxt_s     = (rem_r != '0);
      remaining_nxt_s = rem_r;
    end else begin
      short_nxt_s     = 1'b0;
      remaining_nxt_s = '0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready_r  <= 1'b1;
      coin_valid_r <= 1'b0;
      coin_r       <= COIN_NONE;
      done_r       <= 1'b0;
      short_r      <= 1'b0;
      remaining_r  <= '0;
      fault_r      <= 1'b0;
    end else begin
      req_ready_r  <= req_ready_nxt_s;
      coin_valid_r <= coin_valid_nxt_s;
      coin_r       <= coin_nxt_s;
      done_r       <= done_nxt_s;
      short_r      <= short_nxt_s;
      remaining_r  <= remaining_nxt_s;
      fault_r      <= fault_nxt_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign coin_valid = coin_valid_r;
  assign coin       = coin_r;
  assign done       = done_r;
  assign short      = short_r;
  assign remaining  = remaining_r;
  assign fault      = fault_r;

endmodule

// File: tb/tb_iiitb_ptv_change_dispenser.sv
// Directed bench for iiitb_ptv_change_dispenser; expectations follow PTV_CHANGE_STOCK_EN.
module tb_iiitb_ptv_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, coin_valid, coin_ack, load, clr_fault;
  logic       done, short, fault;
  logic [3:0] req_amount, remaining;
  logic [1:0] coin;
  logic [7:0] load_tens, load_fives, stock_tens, stock_fives;

  int errors = 0;
  int checks = 0;

  logic [1:0] coins[$];
  int         first_cv, done_cycle;
  logic       got_short;
  logic [3:0] got_rem;

  always #5 clk = ~clk;

  iiitb_ptv_change_dispenser dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .coin(coin), .coin_valid(coin_valid), .coin_ack(coin_ack),
    .load(load), .load_tens(load_tens), .load_fives(load_fives), .clr_fault(clr_fault),
    .done(done), .short(short), .remaining(remaining), .fault(fault),
    .stock_tens(stock_tens), .stock_fives(stock_fives)
  );

  // Issue one request and acknowledge every coin in the cycle it is offered.
  // Cycle 1 is the cycle after the accepting edge.
  task automatic run_req(input logic [3:0] amt);
    coins.delete();
    first_cv = -1; done_cycle = -1; got_short = 1'bx; got_rem = 4'hx;
    @(negedge clk);
    req_valid = 1'b1; req_amount = amt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      if (coin_valid) begin
        coins.push_back(coin);
        if (first_cv < 0) first_cv = k;
        coin_ack = 1'b1;
      end else begin
        coin_ack = 1'b0;
      end
      if (done) begin
        done_cycle = k; got_short = short; got_rem = remaining;
        break;
      end
    end
    coin_ack = 1'b0;
  endtask

  task automatic load_stock(input logic [7:0] t, input logic [7:0] f);
    @(negedge clk);
    load = 1'b1; load_tens = t; load_fives = f;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if ({coin_valid, coin, done, short, fault} !== 6'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=000000", {coin_valid, coin, done, short, fault}); end
    checks++; if ({remaining, stock_tens, stock_fives} !== 20'h0) begin errors++; $display("FAIL reset_rem_stock got=%h exp=0", {remaining, stock_tens, stock_fives}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got=%b exp=1", req_ready); end
    run_req(4'd0);
    checks++; if (coins.size() !== 0) begin errors++; $display("FAIL zero_coins got=%0d exp=0", coins.size()); end
    checks++; if (done_cycle !== 2) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=2", done_cycle); end
    checks++; if ({got_short, got_rem} !== 5'b0) begin errors++; $display("FAIL zero_short_rem got=%b exp=00000", {got_short, got_rem}); end
  endtask

  task automatic test_three();
`ifdef PTV_CHANGE_STOCK_EN
    load_stock(8'd5, 8'd5);
`endif
    run_req(4'd3);
    checks++; if (coins.size() !== 2) begin errors++; $display("FAIL three_ncoins got=%0d exp=2", coins.size()); end
    else begin
      checks++; if (coins[0] !== 2'b10 || coins[1] !== 2'b01) begin errors++; $display("FAIL three_coins got=%b,%b exp=10,01", coins[0], coins[1]); end
    end
    checks++; if (first_cv !== 2) begin errors++; $display("FAIL three_first_cv got=%0d exp=2", first_cv); end
    checks++; if (done_cycle !== 6) begin errors++; $display("FAIL three_done_cycle got=%0d exp=6", done_cycle); end
    checks++; if ({got_short, got_rem} !== 5'b0) begin errors++; $display("FAIL three_short_rem got=%b exp=00000", {got_short, got_rem}); end
`ifdef PTV_CHANGE_STOCK_EN
    checks++; if ({stock_tens, stock_fives} !== {8'd4, 8'd4}) begin errors++; $display("FAIL three_stock got=%0d/%0d exp=4/4", stock_tens, stock_fives); end
`else
    checks++; if ({stock_tens, stock_fives} !== 16'h0) begin errors++; $display("FAIL three_stock got=%0d/%0d exp=0/0", stock_tens, stock_fives); end
`endif
  endtask

  task automatic test_short_or_large();
`ifdef PTV_CHANGE_STOCK_EN
    load_stock(8'd1, 8'd1);
    run_req(4'd4);
    checks++; if (coins.size() !== 2) begin errors++; $display("FAIL short_ncoins got=%0d exp=2", coins.size()); end
    checks++; if ({got_short, got_rem} !== {1'b1, 4'd1}) begin errors++; $display("FAIL short_flag_rem got=%b exp=10001", {got_short, got_rem}); end
    checks++; if ({stock_tens, stock_fives} !== 16'h0) begin errors++; $display("FAIL short_stock got=%0d/%0d exp=0/0", stock_tens, stock_fives); end
    load_stock(8'd3, 8'd0);
    run_req(4'd1);
    checks++; if (coins.size() !== 0) begin errors++; $display("FAIL nooverpay_coins got=%0d exp=0", coins.size()); end
    checks++; if ({got_short, got_rem, done_cycle[3:0]} !== {1'b1, 4'd1, 4'd2}) begin errors++; $display("FAIL nooverpay_done got=%b rem=%0d cyc=%0d exp short=1 rem=1 cyc=2", got_short, got_rem, done_cycle); end
`else
    run_req(4'd15);
    checks++; if (coins.size() !== 8) begin errors++; $display("FAIL large_ncoins got=%0d exp=8", coins.size()); end
    else begin
      checks++; if (coins[6] !== 2'b10 || coins[7] !== 2'b01) begin errors++; $display("FAIL large_tail got=%b,%b exp=10,01", coins[6], coins[7]); end
    end
    checks++; if (done_cycle !== 18) begin errors++; $display("FAIL large_done_cycle got=%0d exp=18", done_cycle); end
    checks++; if ({got_short, got_rem} !== 5'b0) begin errors++; $display("FAIL large_short_rem got=%b exp=00000", {got_short, got_rem}); end
`endif
  endtask

  task automatic test_timeout();
    int cv_cnt, fault_k, bad_coin;
`ifdef PTV_CHANGE_STOCK_EN
    load_stock(8'd5, 8'd5);
`endif
    cv_cnt = 0; fault_k = -1; bad_coin = 0;
    @(negedge clk); req_valid = 1'b1; req_amount = 4'd2;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (coin_valid) begin
        cv_cnt++;
        if (coin !== 2'b10) bad_coin++;
      end
      if (fault) begin fault_k = k; break; end
    end
    checks++; if (cv_cnt !== 16) begin errors++; $display("FAIL timeout_cv_cycles got=%0d exp=16", cv_cnt); end
    checks++; if (fault_k !== 18) begin errors++; $display("FAIL timeout_fault_cycle got=%0d exp=18", fault_k); end
    checks++; if (bad_coin !== 0) begin errors++; $display("FAIL timeout_coin_stable got=%0d exp=0", bad_coin); end
    checks++; if ({req_ready, coin_valid} !== 2'b00) begin errors++; $display("FAIL fault_ready_cv got=%b exp=00", {req_ready, coin_valid}); end
    repeat (3) @(negedge clk);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_hold got=%b exp=1", fault); end
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    checks++; if ({req_ready, fault} !== 2'b10) begin errors++; $display("FAIL clr_fault got=%b exp=10", {req_ready, fault}); end
`ifdef PTV_CHANGE_STOCK_EN
    checks++; if (stock_tens !== 8'd5) begin errors++; $display("FAIL timeout_stock got=%0d exp=5", stock_tens); end
`endif
  endtask

  task automatic test_last_cycle_ack();
    int cv_cnt, fault_seen, dk;
    cv_cnt = 0; fault_seen = 0; dk = -1;
    @(negedge clk); req_valid = 1'b1; req_amount = 4'd2;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (fault) fault_seen = 1;
      if (coin_valid) begin
        cv_cnt++;
        coin_ack = (cv_cnt == 16);
      end else begin
        coin_ack = 1'b0;
      end
      if (done) begin dk = k; break; end
    end
    coin_ack = 1'b0;
    checks++; if (fault_seen !== 0) begin errors++; $display("FAIL lastack_fault got=%0d exp=0", fault_seen); end
    checks++; if (dk !== 19) begin errors++; $display("FAIL lastack_done_cycle got=%0d exp=19", dk); end
    checks++; if ({short, remaining} !== 5'b0) begin errors++; $display("FAIL lastack_short_rem got=%b exp=00000", {short, remaining}); end
  endtask

  task automatic test_back_to_back();
`ifdef PTV_CHANGE_STOCK_EN
    load_stock(8'd2, 8'd2);
`endif
    run_req(4'd2);
    checks++; if (coins.size() !== 1 || coins[0] !== 2'b10 || done_cycle !== 4) begin errors++; $display("FAIL b2b_first n=%0d cyc=%0d exp n=1 coin=10 cyc=4", coins.size(), done_cycle); end
    run_req(4'd1);
    checks++; if (coins.size() !== 1 || coins[0] !== 2'b01 || done_cycle !== 4) begin errors++; $display("FAIL b2b_second n=%0d cyc=%0d exp n=1 coin=01 cyc=4", coins.size(), done_cycle); end
`ifdef PTV_CHANGE_STOCK_EN
    checks++; if ({stock_tens, stock_fives} !== {8'd1, 8'd1}) begin errors++; $display("FAIL b2b_stock got=%0d/%0d exp=1/1", stock_tens, stock_fives); end
`endif
  endtask

  task automatic test_reset_mid_issue();
    int seen;
    seen = 0;
`ifdef PTV_CHANGE_STOCK_EN
    load_stock(8'd2, 8'd2);
`endif
    @(negedge clk); req_valid = 1'b1; req_amount = 4'd2;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    for (int k = 0; k < 10 && !coin_valid; k++) @(negedge clk);
    checks++; if (coin_valid !== 1'b1) begin errors++; $display("FAIL rstmid_cv_before got=%b exp=1", coin_valid); end
    rst = 1'b0;
    #1;
    checks++; if ({req_ready, coin_valid, coin, done, short, fault} !== 7'b1000000) begin errors++; $display("FAIL rstmid_outputs got=%b exp=1000000", {req_ready, coin_valid, coin, done, short, fault}); end
    checks++; if ({remaining, stock_tens, stock_fives} !== 20'h0) begin errors++; $display("FAIL rstmid_rem_stock got=%h exp=0", {remaining, stock_tens, stock_fives}); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (coin_valid || done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_idle got=%0d exp=0", seen); end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_amount = 4'd0; coin_ack = 1'b0;
    load = 1'b0; load_tens = 8'd0; load_fives = 8'd0; clr_fault = 1'b0;
    test_reset();
    test_zero();
    test_three();
    test_short_or_large();
    test_timeout();
    test_last_cycle_ack();
    test_back_to_back();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
